// File: rtl/risc8_uart_rx.sv
// risc8 IO-bus UART receiver: 2-flop sync, 8N1 deframer, small FIFO.
// Ports: clk, reset(async low), addr/ren/wen/wdata in, rdata/valid out,
//        serial_rx line in, rx_ready (FIFO non-empty) out.
module risc8_uart_rx #(
  parameter logic [6:0] BASE      = 7'h2C,
  parameter int         DIVISOR   = 104,
  parameter int         FIFO_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] addr,
  input  logic       ren,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  input  logic       serial_rx,
  output logic       rx_ready
);

  localparam logic [6:0] STAT = BASE + 7'd1;
  localparam int CW    = $clog2(DIVISOR);
  localparam int PW    = FIFO_BITS + 1;
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [CW-1:0] FULLC = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALFC = CW'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BRK
  } state_e;

  logic          meta_q, rxs_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;

  logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          ovr_q, ferr_q;
  logic [7:0]    rdata_q, rdata_d;
  logic          valid_q;

  logic stop_done, push, ferr_set;
  logic empty, full;
  logic rd_data, rd_stat, w1c, pop, push_ok, ovr_set;
  logic [7:0] status;
  logic unused_wdata;

  assign unused_wdata = ^{wdata[7:3], wdata[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= serial_rx;
      rxs_q  <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= HALFC;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (!rxs_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
              cnt_q   <= FULLC;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q[idx_q] <= rxs_q;
            cnt_q          <= FULLC;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else idx_q <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            state_q <= rxs_q ? S_IDLE : S_BRK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_BRK: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stop_done = (state_q == S_STOP) && (cnt_q == '0);
  assign push      = stop_done && rxs_q;
  assign ferr_set  = stop_done && !rxs_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-2:0] == rptr_q[PW-2:0]) &&
                 (wptr_q[PW-1] != rptr_q[PW-1]);

  assign rd_data = ren && (addr == BASE);
  assign rd_stat = ren && (addr == STAT);
  assign w1c     = wen && (addr == STAT);
  assign pop     = rd_data && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO lands.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  assign status = {4'b0, full, ferr_q, ovr_q, !empty};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
  end

  always_comb begin
    rdata_d = 8'h00;
    unique case (1'b1)
      rd_data: rdata_d = empty ? 8'h00 : mem_q[rptr_q[PW-2:0]];
      rd_stat: rdata_d = status;
      default: rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      rdata_q <= 8'h00;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (push_ok) mem_q[wptr_q[PW-2:0]] <= shift_q;
      ovr_q   <= ovr_set | (ovr_q & ~(w1c & wdata[1]));
      ferr_q  <= ferr_set | (ferr_q & ~(w1c & wdata[2]));
      rdata_q <= rdata_d;
      valid_q <= rd_data | rd_stat;
    end
  end

  assign rdata    = rdata_q;
  assign valid    = valid_q;
  assign rx_ready = !empty;

endmodule
